// File: rtl/mac6_seq_if.sv
// Command, operand-stream and result bundle for the mac6_seq dot-product sequencer.
// A transfer happens on a clock edge where both valid and ready are high; valid never waits on ready.
interface mac6_seq_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        cfg_len;
    logic                    cfg_op;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [5:0]       in_a;
    logic signed [5:0]       in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [11:0]      out_result;
    logic                    out_ovf;

    modport master (
        output start, cfg_len, cfg_op, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_result, out_ovf
    );

    modport slave (
        input  start, cfg_len, cfg_op, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/mac6_seq.sv
// Sequencer streaming signed 6-bit pairs through one MAC6 into a 12-bit accumulator.
// Build option MAC6_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module mac6_seq #(
    parameter int LEN_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mac6_seq_if.slave  bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic signed [11:0] acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic               op_q;
    logic               ovf;

    logic               accept;
    logic               last;
    logic signed [11:0] prod;
    logic signed [12:0] mac_out;
    logic               ovf_step;
    logic signed [11:0] next_acc;

    // MAC6 datapath: 13-bit result so the overflow check sees the true sign.
    assign prod     = bus.in_a * bus.in_b;
    assign mac_out  = op_q ? ({prod[11], prod} - {acc[11], acc})
                           : ({prod[11], prod} + {acc[11], acc});
    assign ovf_step = mac_out[12] ^ mac_out[11];

`ifdef MAC6_SAT_EN
    assign next_acc = !ovf_step   ? mac_out[11:0]
                    : mac_out[12] ? 12'sh800
                    :               12'sh7FF;
`else
    assign next_acc = mac_out[11:0];
`endif

    assign accept = (state == S_RUN) && bus.in_valid;
    assign last   = (cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = (bus.cfg_len == '0) ? S_DONE : S_RUN;
            S_RUN:  if (accept && last) state_nx = S_DONE;
            S_DONE: if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.in_ready   = (state == S_RUN);
        bus.out_valid  = (state == S_DONE);
        bus.out_result = (state == S_DONE) ? acc : 12'sd0;
        bus.out_ovf    = (state == S_DONE) ? ovf : 1'b0;
        dbg_state      = state;
    end

    // cnt returns to zero on the last accept so it never runs past len.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            op_q  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    len_q <= bus.cfg_len;
                    op_q  <= bus.cfg_op;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
                S_RUN: if (accept) begin
                    acc <= next_acc;
                    cnt <= last ? '0 : cnt + LEN_W'(1);
                    if (ovf_step) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac6_seq.sv
// Bench for mac6_seq: directed scenarios plus randomized commands against an integer reference model.
module tb_mac6_seq;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;

  int         op_a_q[$];
  int         op_b_q[$];
  logic [12:0] exp_q[$];

  mac6_seq_if #(.LEN_W(8)) bus ();

  mac6_seq #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got running required finished");
    $fatal(1, "watchdog");
  end

  // reference: spec recurrence in plain integers, overflow outside [-2048, 2047]
  function automatic logic [12:0] model(input int n, input bit op);
    int r;
    int p;
    bit ov;
    r  = 0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = op_a_q[i] * op_b_q[i];
      r = op ? (p - r) : (p + r);
      if (r > 2047 || r < -2048) begin
        ov = 1'b1;
`ifdef MAC6_SAT_EN
        r = (r > 2047) ? 2047 : -2048;
`else
        r = ((r + 2048) & 4095) - 2048;
`endif
      end
    end
    return {ov, r[11:0]};
  endfunction

  function automatic logic [12:0] mk(input bit ov, input int r);
    return {ov, r[11:0]};
  endfunction

  task automatic set_ops(input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int n);
    op_a_q = {};
    op_b_q = {};
    if (n > 0) begin op_a_q.push_back(a0); op_b_q.push_back(b0); end
    if (n > 1) begin op_a_q.push_back(a1); op_b_q.push_back(b1); end
    if (n > 2) begin op_a_q.push_back(a2); op_b_q.push_back(b2); end
  endtask

  // driver: one full command, ends at a negedge with the DUT back in IDLE
  task automatic do_cmd(input int len, input bit op, input int gap_pct, input int hold,
                        input logic [12:0] exp, input string name);
    int idx;
    int cyc;
    bit took;
    logic [12:0] got;
    exp_q.push_back(exp);
    bus.start   = 1'b1;
    bus.cfg_len = len[7:0];
    bus.cfg_op  = op;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.cfg_len = 8'($urandom);
    bus.cfg_op  = 1'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < len * 4 + 50) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_a = 6'(op_a_q[idx]);
      bus.in_b = 6'(op_b_q[idx]);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s run_hs: in_ready=%b out_valid=%b busy=%b required 1 0 1",
                 name, bus.in_ready, bus.out_valid, bus.busy);
      end
      took = bus.in_valid;
      @(posedge clk); #1;
      cyc++;
      if (took) idx++;
    end
    if (idx < len) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s feed_timeout: accepted %0d required %0d", name, idx, len);
    end
    // first cycle after the last accept (or after start for len=0)
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom);
      bus.start     = (h == 0);
      bus.cfg_len   = 8'($urandom_range(1, 255));
      bus.cfg_op    = 1'($urandom);
      @(negedge clk);
      got = {bus.out_ovf, bus.out_result};
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || got !== exp) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b busy=%b in_ready=%b res=%h required 1 1 0 %h",
                 name, h, bus.out_valid, bus.busy, bus.in_ready, got, exp);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'($urandom);
    @(negedge clk);
    got = {bus.out_ovf, bus.out_result};
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== exp) begin
      n_fail++;
      $display("FAIL %s result: valid=%b in_ready=%b {ovf,res}=%h required 1 0 %h",
               name, bus.out_valid, bus.in_ready, got, exp);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s after_hs: valid=%b busy=%b state=%0d required 0 0 0",
               name, bus.out_valid, bus.busy, dbg_state);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_result !== 12'sd0 || bus.out_ovf !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: busy=%b in_ready=%b valid=%b res=%0d ovf=%b state=%0d required all 0",
               name, bus.busy, bus.in_ready, bus.out_valid, bus.out_result, bus.out_ovf, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_op = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_dot();
    set_ops(3, 4, -5, 6, 31, -32, 3);
    do_cmd(3, 1'b0, 0, 0, mk(1'b0, -1010), "dot");
  endtask

  task automatic test_alternating();
    set_ops(2, 3, 4, 5, 1, 1, 3);
    do_cmd(3, 1'b1, 0, 0, mk(1'b0, -13), "alt");
  endtask

  task automatic test_overflow();
    set_ops(-32, -32, -32, -32, 0, 0, 2);
`ifdef MAC6_SAT_EN
    do_cmd(2, 1'b0, 0, 0, mk(1'b1, 2047), "ovf");
`else
    do_cmd(2, 1'b0, 0, 0, mk(1'b1, -2048), "ovf");
`endif
  endtask

  task automatic test_back_to_back();
    set_ops(0, 0, 0, 0, 0, 0, 0);
    do_cmd(0, 1'b0, 0, 2, mk(1'b0, 0), "empty");
    set_ops(5, 5, -6, 7, 0, 0, 2);
    do_cmd(2, 1'b0, 0, 3, mk(1'b0, -17), "b2b");
  endtask

  task automatic test_backpressure();
    set_ops(1, 1, 1, 1, 1, 1, 3);
    op_a_q.push_back(1);
    op_b_q.push_back(1);
    do_cmd(4, 1'b0, 50, 5, mk(1'b0, 4), "bp");
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.cfg_len = 8'd4; bus.cfg_op = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 6'sd9; bus.in_b = 6'sd9;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    set_ops(7, -3, 0, 0, 0, 0, 1);
    do_cmd(1, 1'b0, 0, 0, mk(1'b0, -21), "post_rst");
  endtask

  task automatic test_random();
    int n;
    bit op;
    for (int t = 0; t < 24; t++) begin
      n  = (t == 23) ? 255 : $urandom_range(0, 12);
      op = 1'($urandom);
      op_a_q = {};
      op_b_q = {};
      for (int i = 0; i < n; i++) begin
        op_a_q.push_back($urandom_range(63) - 32);
        op_b_q.push_back($urandom_range(63) - 32);
      end
      do_cmd(n, op, $urandom_range(0, 40), $urandom_range(0, 3), model(n, op), "rand");
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_dot();
    test_alternating();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
